// File: rtl/jesd204_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jesd204_pkg
//  Brief    : Shared JESD204 link state encoding and control characters.
//  Revision : 1.0 - initial release
// ============================================================================
package jesd204_pkg;

    typedef enum logic [1:0] {
        STATE_RESET = 2'd0,
        STATE_CGS   = 2'd1,
        STATE_ILAS  = 2'd2,
        STATE_DATA  = 2'd3
    } link_state_t;

    localparam logic [7:0] K_R = 8'h1C;
    localparam logic [7:0] K_A = 8'h7C;
    localparam logic [7:0] K_Q = 8'h9C;
    localparam logic [7:0] K_K = 8'hBC;

endpackage
`default_nettype wire

// File: rtl/jesd204_tx_ilas_gen.sv
`default_nettype none
// ============================================================================
//  Module   : jesd204_tx_ilas_gen
//  Brief    : Builds one registered ILAS beat per cycle and issues config reads.
//  Revision : 1.0 - initial release
// ============================================================================
module jesd204_tx_ilas_gen
    import jesd204_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [7:0]  i_b,
    input  logic [1:0]  i_m,
    input  logic        i_last,
    input  logic [7:0]  i_beats_last,
    input  logic [31:0] i_cfg_data,
    output logic [31:0] o_data,
    output logic [3:0]  o_charisk,
    output logic        o_cfg_rd,
    output logic [1:0]  o_cfg_addr
);

    logic [31:0] w_data;
    logic [3:0]  w_charisk;
    logic        w_rd;
    logic [1:0]  w_addr;

    always_comb begin
        w_data    = {i_b[5:0], 2'd3, i_b[5:0], 2'd2, i_b[5:0], 2'd1, i_b[5:0], 2'd0};
        w_charisk = '0;
        if (i_m == 2'd1) begin
            if (i_b == 8'd0) begin
                w_data[31:16] = i_cfg_data[31:16];
                w_data[15:8]  = K_Q;
                w_charisk[1]  = 1'b1;
            end else if (i_b <= 8'd3) begin
                w_data = i_cfg_data;
            end
        end
        if (i_b == 8'd0) begin
            w_data[7:0]  = K_R;
            w_charisk[0] = 1'b1;
        end
        if (i_last) begin
            w_data[31:24] = K_A;
            w_charisk[3]  = 1'b1;
        end

        // The read targets the beat assembled two cycles from now, so the
        // word arrives in the cycle that beat is latched into o_data.
        w_rd   = 1'b0;
        w_addr = 2'd0;
        if ((i_m == 2'd0) && (({1'b0, i_b} + 9'd1) == {1'b0, i_beats_last})) begin
            w_rd   = 1'b1;
            w_addr = 2'd0;
        end else if ((i_m == 2'd0) && i_last) begin
            w_rd   = 1'b1;
            w_addr = 2'd1;
        end else if ((i_m == 2'd1) && (i_b < 8'd2)) begin
            w_rd   = 1'b1;
            w_addr = i_b[1:0] + 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            o_data     <= '0;
            o_charisk  <= '0;
            o_cfg_rd   <= 1'b0;
            o_cfg_addr <= 2'd0;
        end else begin
            o_data     <= w_data;
            o_charisk  <= w_charisk;
            o_cfg_rd   <= w_rd;
            o_cfg_addr <= w_addr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_bits.sv
`default_nettype none
// ============================================================================
//  Module   : sync_bits
//  Brief    : Two-flop synchronizer for a single asynchronous control bit.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_bits (
    input  logic clk,
    input  logic i_in,
    output logic o_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        r_meta <= i_in;
        r_sync <= r_meta;
    end

    assign o_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/jesd204_tx_link_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : jesd204_tx_link_sequencer
//  Brief    : Sequences the TX link through CGS, ILAS and DATA from SYNC~/LMFC.
//  Revision : 1.0 - initial release
// ============================================================================
module jesd204_tx_link_sequencer
    import jesd204_pkg::*;
#(
    parameter int DATA_PATH_WIDTH  = 4,
    parameter int SYNC_LOSS_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sync,
    input  logic                         lmfc_edge,
    input  logic [7:0]                   cfg_beats_per_multiframe,
    input  logic                         cfg_skip_ilas,
    input  logic                         cfg_continuous_cgs,
    output logic                         ilas_config_rd,
    output logic [1:0]                   ilas_config_addr,
    input  logic [31:0]                  ilas_config_data,
    output logic                         cgs_enable,
    output logic [8*DATA_PATH_WIDTH-1:0] ilas_data,
    output logic [DATA_PATH_WIDTH-1:0]   ilas_charisk,
    output logic                         tx_ready,
    output logic [1:0]                   status_state
);

    localparam logic [8:0] c_loss = 9'(SYNC_LOSS_CYCLES);

    link_state_t r_state;
    logic        r_cgs_enable;
    logic        r_tx_ready;
    logic [7:0]  r_b;
    logic [1:0]  r_m;
    logic [7:0]  r_low_cnt;

    logic        w_sync_s;
    logic        w_leave_cgs;
    logic        w_sync_loss;
    logic        w_ilas_done;
    logic [7:0]  w_low_cnt_next;
    logic        w_en;
    logic [7:0]  w_b;
    logic [1:0]  w_m;

    sync_bits u_sync_bits (
        .clk   (clk),
        .i_in  (sync),
        .o_out (w_sync_s)
    );

    assign w_leave_cgs    = lmfc_edge && w_sync_s && !cfg_continuous_cgs;
    assign w_sync_loss    = !w_sync_s && (({1'b0, r_low_cnt} + 9'd1) >= c_loss);
    assign w_ilas_done    = (r_m == 2'd3) && (r_b == cfg_beats_per_multiframe);
    assign w_low_cnt_next = w_sync_s ? 8'd0 :
                            (({1'b0, r_low_cnt} >= c_loss) ? r_low_cnt : r_low_cnt + 8'd1);

    // r_b/r_m describe the beat on the outputs; w_b/w_m the beat latched next.
    always_comb begin
        w_en = 1'b0;
        w_b  = 8'd0;
        w_m  = 2'd0;
        if ((r_state == STATE_CGS) && w_leave_cgs && !cfg_skip_ilas) begin
            w_en = 1'b1;
        end else if ((r_state == STATE_ILAS) && !w_sync_loss && !w_ilas_done) begin
            w_en = 1'b1;
            if (r_b == cfg_beats_per_multiframe) begin
                w_m = r_m + 2'd1;
            end else begin
                w_b = r_b + 8'd1;
                w_m = r_m;
            end
        end
    end

    jesd204_tx_ilas_gen u_ilas_gen (
        .clk          (clk),
        .rst          (reset),
        .i_en         (w_en),
        .i_b          (w_b),
        .i_m          (w_m),
        .i_last       (w_b == cfg_beats_per_multiframe),
        .i_beats_last (cfg_beats_per_multiframe),
        .i_cfg_data   (ilas_config_data),
        .o_data       (ilas_data),
        .o_charisk    (ilas_charisk),
        .o_cfg_rd     (ilas_config_rd),
        .o_cfg_addr   (ilas_config_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= STATE_RESET;
            r_cgs_enable <= 1'b1;
            r_tx_ready   <= 1'b0;
            r_b          <= 8'd0;
            r_m          <= 2'd0;
            r_low_cnt    <= 8'd0;
        end else begin
            if (w_en) begin
                r_b <= w_b;
                r_m <= w_m;
            end
            case (r_state)
                STATE_RESET: begin
                    r_state      <= STATE_CGS;
                    r_cgs_enable <= 1'b1;
                    r_tx_ready   <= 1'b0;
                end
                STATE_CGS: begin
                    r_low_cnt <= 8'd0;
                    if (w_leave_cgs) begin
                        r_cgs_enable <= 1'b0;
                        if (cfg_skip_ilas) begin
                            r_state    <= STATE_DATA;
                            r_tx_ready <= 1'b1;
                        end else begin
                            r_state <= STATE_ILAS;
                        end
                    end
                end
                STATE_ILAS, STATE_DATA: begin
                    if (w_sync_loss) begin
                        r_state      <= STATE_CGS;
                        r_cgs_enable <= 1'b1;
                        r_tx_ready   <= 1'b0;
                        r_low_cnt    <= 8'd0;
                    end else begin
                        r_low_cnt <= w_low_cnt_next;
                        if ((r_state == STATE_ILAS) && w_ilas_done) begin
                            r_state    <= STATE_DATA;
                            r_tx_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= STATE_RESET;
                end
            endcase
        end
    end

    assign status_state = r_state;
    assign cgs_enable   = r_cgs_enable;
    assign tx_ready     = r_tx_ready;

endmodule
`default_nettype wire
